// File: rtl/bicubic_pkg.sv
// rtl/bicubic_pkg.sv - shared constants and state encoding for the bicubic scaler
package bicubic_pkg;

    localparam int FRAC_W = 8;
    localparam logic [FRAC_W:0] COEFF_ONE  = 9'd256;
    localparam logic [FRAC_W:0] COEFF_HALF = 9'd128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bicubic_axis_acc.sv
// rtl/bicubic_axis_acc.sv - per-axis saturating phase accumulator with clamp to source dimension
module bicubic_axis_acc
    import bicubic_pkg::*;
#(
    parameter int COORD_W = 12,
    parameter int STEP_W  = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               add_en,
    input  logic [STEP_W-1:0]  step,
    input  logic [COORD_W-1:0] dim,
    output logic [COORD_W-1:0] coord_int,
    output logic [FRAC_W-1:0]  blend
);

    localparam int ACC_W = COORD_W + FRAC_W;
    localparam int SUM_W = ACC_W + 1;
    localparam logic [COORD_W-1:0] ONE_C = COORD_W'(1);

    logic [ACC_W-1:0]   acc;
    logic [SUM_W-1:0]   sum;
    logic [COORD_W-1:0] int_part;

    // Carry out of the top bit means the coordinate ran past the representable range.
    assign sum      = {1'b0, acc} + SUM_W'(step);
    assign int_part = acc[ACC_W-1:FRAC_W];

    always_ff @(posedge clk) begin
        if (rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (add_en) begin
            acc <= sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
        end
    end

    always_comb begin
        coord_int = int_part;
        blend     = acc[FRAC_W-1:0];
        if (int_part >= dim) begin
            coord_int = dim - ONE_C;
            blend     = '0;
        end
    end

endmodule

// File: rtl/bicubic_phase_gen.sv
// rtl/bicubic_phase_gen.sv - destination raster walker emitting clamped source coords and blend phases
module bicubic_phase_gen
    import bicubic_pkg::*;
#(
    parameter int COORD_W = 12,
    parameter int STEP_W  = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COORD_W-1:0] src_w,
    input  logic [COORD_W-1:0] src_h,
    input  logic [COORD_W-1:0] dst_w,
    input  logic [COORD_W-1:0] dst_h,
    input  logic [STEP_W-1:0]  step_x,
    input  logic [STEP_W-1:0]  step_y,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [COORD_W-1:0] out_x_int,
    output logic [COORD_W-1:0] out_y_int,
    output logic [FRAC_W:0]    x_blend,
    output logic [FRAC_W:0]    y_blend,
    output logic [FRAC_W:0]    coeff_one,
    output logic [FRAC_W:0]    coeff_half,
    output logic               out_eol,
    output logic               out_eof,
    output logic               busy,
    output logic               done
);

    localparam logic [COORD_W-1:0] ONE_C = COORD_W'(1);

    state_t state, state_nxt;

    logic [COORD_W-1:0] src_w_q, src_h_q, dst_w_q, dst_h_q;
    logic [STEP_W-1:0]  step_x_q, step_y_q;
    logic [COORD_W-1:0] dx, dy;
    logic               pending;
    logic [COORD_W-1:0] x_coord, y_coord;
    logic [FRAC_W-1:0]  x_frac, y_frac, x_blend_q, y_blend_q;

    logic start_ok, zero_dim, load, eol_n, eof_n, xfer_last;

    assign start_ok  = (state == ST_IDLE) && start;
    assign zero_dim  = (dst_w == '0) || (dst_h == '0);
    // The accumulators describe the next beat; it moves into the output register when that slot frees.
    assign load      = (state == ST_RUN) && pending && (!out_valid || out_ready);
    assign eol_n     = (dx == dst_w_q - ONE_C);
    assign eof_n     = eol_n && (dy == dst_h_q - ONE_C);
    assign xfer_last = out_valid && out_ready && out_eof;

    bicubic_axis_acc #(.COORD_W(COORD_W), .STEP_W(STEP_W)) u_acc_x (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (start_ok || (load && eol_n)),
        .add_en    (load && !eol_n),
        .step      (step_x_q),
        .dim       (src_w_q),
        .coord_int (x_coord),
        .blend     (x_frac)
    );

    bicubic_axis_acc #(.COORD_W(COORD_W), .STEP_W(STEP_W)) u_acc_y (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (start_ok),
        .add_en    (load && eol_n),
        .step      (step_y_q),
        .dim       (src_h_q),
        .coord_int (y_coord),
        .blend     (y_frac)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = zero_dim ? ST_DONE : ST_RUN;
            ST_RUN:  if (xfer_last) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state     <= ST_IDLE;
            src_w_q   <= '0;
            src_h_q   <= '0;
            dst_w_q   <= '0;
            dst_h_q   <= '0;
            step_x_q  <= '0;
            step_y_q  <= '0;
            dx        <= '0;
            dy        <= '0;
            pending   <= 1'b0;
            out_valid <= 1'b0;
            out_x_int <= '0;
            out_y_int <= '0;
            x_blend_q <= '0;
            y_blend_q <= '0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                src_w_q  <= src_w;
                src_h_q  <= src_h;
                dst_w_q  <= dst_w;
                dst_h_q  <= dst_h;
                step_x_q <= step_x;
                step_y_q <= step_y;
                dx       <= '0;
                dy       <= '0;
                pending  <= !zero_dim;
            end
            if (load) begin
                out_valid <= 1'b1;
                out_x_int <= x_coord;
                out_y_int <= y_coord;
                x_blend_q <= x_frac;
                y_blend_q <= y_frac;
                out_eol   <= eol_n;
                out_eof   <= eof_n;
                if (eol_n) begin
                    dx <= '0;
                    dy <= dy + ONE_C;
                end else begin
                    dx <= dx + ONE_C;
                end
                if (eof_n) pending <= 1'b0;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_eol   <= 1'b0;
                out_eof   <= 1'b0;
            end
        end
    end

    assign x_blend    = {1'b0, x_blend_q};
    assign y_blend    = {1'b0, y_blend_q};
    assign coeff_one  = COEFF_ONE;
    assign coeff_half = COEFF_HALF;
    assign busy       = (state == ST_RUN);
    assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_bicubic_phase_gen.sv
// tb/tb_bicubic_phase_gen.sv - directed self-checking bench for bicubic_phase_gen
module tb_bicubic_phase_gen;

    localparam int COORD_W = 12;
    localparam int STEP_W  = 20;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               start = 1'b0;
    logic [COORD_W-1:0] src_w = '0, src_h = '0, dst_w = '0, dst_h = '0;
    logic [STEP_W-1:0]  step_x = '0, step_y = '0;
    logic               out_ready = 1'b1;
    logic               out_valid;
    logic [COORD_W-1:0] out_x_int, out_y_int;
    logic [8:0]         x_blend, y_blend, coeff_one, coeff_half;
    logic               out_eol, out_eof, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    int nb, done_cnt, done_cyc, last_cyc;
    int cx[16], cy[16], cxb[16], cyb[16], ceol[16], ceof[16];

    always #5 clk = ~clk;

    bicubic_phase_gen #(.COORD_W(COORD_W), .STEP_W(STEP_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .src_w      (src_w),
        .src_h      (src_h),
        .dst_w      (dst_w),
        .dst_h      (dst_h),
        .step_x     (step_x),
        .step_y     (step_y),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_x_int  (out_x_int),
        .out_y_int  (out_y_int),
        .x_blend    (x_blend),
        .y_blend    (y_blend),
        .coeff_one  (coeff_one),
        .coeff_half (coeff_half),
        .out_eol    (out_eol),
        .out_eof    (out_eof),
        .busy       (busy),
        .done       (done)
    );

    task automatic start_frame(input int sw, input int sh, input int dw, input int dh,
                               input int stx, input int sty);
        @(negedge clk);
        src_w  = COORD_W'(sw);
        src_h  = COORD_W'(sh);
        dst_w  = COORD_W'(dw);
        dst_h  = COORD_W'(dh);
        step_x = STEP_W'(stx);
        step_y = STEP_W'(sty);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Records accepted beats (valid && ready seen at the falling edge) until one cycle after done.
    task automatic capture(input int max_cyc);
        nb = 0; done_cnt = 0; done_cyc = -1; last_cyc = -1;
        for (int c = 0; c < max_cyc; c++) begin
            if (out_valid && out_ready && nb < 16) begin
                cx[nb] = int'(out_x_int); cy[nb] = int'(out_y_int);
                cxb[nb] = int'(x_blend);  cyb[nb] = int'(y_blend);
                ceol[nb] = int'(out_eol); ceof[nb] = int'(out_eof);
                last_cyc = c;
                nb++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (done_cyc >= 0 && c > done_cyc) break;
            @(negedge clk);
        end
    endtask

    task automatic check_frame(input string name, input int n, input int ex[8], input int ey[8],
                               input int exb[8], input int eol_mask, input int eof_mask);
        n_checks++;
        if (nb !== n) begin
            n_fail++;
            $display("FAIL %s beat_count: got %0d expected %0d", name, nb, n);
        end
        for (int i = 0; i < n && i < nb; i++) begin
            n_checks++;
            if (cx[i] !== ex[i] || cy[i] !== ey[i] || cxb[i] !== exb[i] || cyb[i] !== 0 ||
                ceol[i] !== ((eol_mask >> i) & 1) || ceof[i] !== ((eof_mask >> i) & 1)) begin
                n_fail++;
                $display("FAIL %s beat%0d: got x=%0d y=%0d xb=%0d yb=%0d eol=%0d eof=%0d expected x=%0d y=%0d xb=%0d yb=0 eol=%0d eof=%0d",
                         name, i, cx[i], cy[i], cxb[i], cyb[i], ceol[i], ceof[i],
                         ex[i], ey[i], exb[i], (eol_mask >> i) & 1, (eof_mask >> i) & 1);
            end
        end
        n_checks++;
        if (done_cnt !== 1 || done_cyc !== last_cyc + 1) begin
            n_fail++;
            $display("FAIL %s done_timing: got count=%0d cyc=%0d expected count=1 cyc=%0d",
                     name, done_cnt, done_cyc, last_cyc + 1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({out_valid, busy, done, out_eol, out_eof} !== 5'b0 || out_x_int !== '0 ||
            out_y_int !== '0 || x_blend !== '0 || y_blend !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%0b b=%0b d=%0b x=%0d y=%0d xb=%0d yb=%0d expected all zero",
                     out_valid, busy, done, out_x_int, out_y_int, x_blend, y_blend);
        end
        n_checks++;
        if (coeff_one !== 9'd256 || coeff_half !== 9'd128) begin
            n_fail++;
            $display("FAIL reset_coeffs: got %0d/%0d expected 256/128", coeff_one, coeff_half);
        end
        rst_n = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_identity();
        int ex[8], ey[8], exb[8];
        ex = '{0, 1, 2, 3, 0, 1, 2, 3};
        ey = '{0, 0, 0, 0, 1, 1, 1, 1};
        exb = '{0, 0, 0, 0, 0, 0, 0, 0};
        out_ready = 1'b1;
        start_frame(4, 2, 4, 2, 256, 256);
        n_checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL identity_first_cycle: got busy=%0b valid=%0b expected busy=1 valid=0", busy, out_valid);
        end
        capture(40);
        check_frame("identity", 8, ex, ey, exb, 8'h88, 8'h80);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL identity_idle_after: got busy=%0b done=%0b expected 0/0", busy, done);
        end
    endtask

    task automatic test_upscale();
        int ex[8], ey[8], exb[8];
        ex = '{0, 0, 1, 1, 0, 0, 0, 0};
        ey = '{0, 0, 0, 0, 0, 0, 0, 0};
        exb = '{0, 128, 0, 128, 0, 0, 0, 0};
        out_ready = 1'b1;
        start_frame(2, 1, 4, 1, 128, 256);
        capture(40);
        check_frame("upscale", 4, ex, ey, exb, 8'h08, 8'h08);
        n_checks++;
        if (coeff_one !== 9'd256 || coeff_half !== 9'd128) begin
            n_fail++;
            $display("FAIL upscale_coeffs: got %0d/%0d expected 256/128", coeff_one, coeff_half);
        end
    endtask

    task automatic test_clamp();
        int ex[8], ey[8], exb[8];
        ex = '{0, 1, 3, 3, 0, 0, 0, 0};
        ey = '{0, 0, 0, 0, 0, 0, 0, 0};
        exb = '{0, 128, 0, 0, 0, 0, 0, 0};
        out_ready = 1'b1;
        start_frame(4, 1, 4, 1, 384, 256);
        capture(40);
        check_frame("clamp", 4, ex, ey, exb, 8'h08, 8'h08);
    endtask

    task automatic test_backpressure();
        int ex[8], ey[8], exb[8];
        int stalls;
        ex = '{0, 0, 1, 1, 0, 0, 0, 0};
        ey = '{0, 0, 0, 0, 0, 0, 0, 0};
        exb = '{0, 128, 0, 128, 0, 0, 0, 0};
        stalls = 0;
        out_ready = 1'b1;
        start_frame(2, 1, 4, 1, 128, 256);
        nb = 0; done_cnt = 0; done_cyc = -1; last_cyc = -1;
        for (int c = 0; c < 40; c++) begin
            if (out_valid && nb == 1 && stalls < 3) begin
                out_ready = 1'b0;
                stalls++;
                n_checks++;
                if (out_x_int !== 12'd0 || x_blend !== 9'd128 || out_eol !== 1'b0) begin
                    n_fail++;
                    $display("FAIL backpressure_hold%0d: got x=%0d xb=%0d eol=%0b expected x=0 xb=128 eol=0",
                             stalls, out_x_int, x_blend, out_eol);
                end
            end else begin
                out_ready = 1'b1;
                if (out_valid && nb < 16) begin
                    cx[nb] = int'(out_x_int); cy[nb] = int'(out_y_int);
                    cxb[nb] = int'(x_blend);  cyb[nb] = int'(y_blend);
                    ceol[nb] = int'(out_eol); ceof[nb] = int'(out_eof);
                    last_cyc = c;
                    nb++;
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (done_cyc >= 0 && c > done_cyc) break;
            @(negedge clk);
        end
        out_ready = 1'b1;
        n_checks++;
        if (stalls !== 3) begin
            n_fail++;
            $display("FAIL backpressure_stalls: got %0d expected 3", stalls);
        end
        check_frame("backpressure", 4, ex, ey, exb, 8'h08, 8'h08);
    endtask

    task automatic test_zero_dim();
        int seen_valid, seen_done;
        seen_valid = 0; seen_done = 0;
        out_ready = 1'b1;
        start_frame(4, 2, 0, 2, 256, 256);
        n_checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_dim_done: got done=%0b valid=%0b busy=%0b expected 1/0/0", done, out_valid, busy);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) seen_valid++;
            if (done) seen_done++;
        end
        n_checks++;
        if (seen_valid !== 0 || seen_done !== 0) begin
            n_fail++;
            $display("FAIL zero_dim_quiet: got valid_cycles=%0d done_cycles=%0d expected 0/0", seen_valid, seen_done);
        end
    endtask

    task automatic test_reset_mid_frame();
        int got, seen_done;
        got = 0; seen_done = 0;
        out_ready = 1'b1;
        start_frame(4, 2, 4, 2, 256, 256);
        for (int c = 0; c < 20 && got < 3; c++) begin
            if (out_valid && out_ready) got++;
            @(negedge clk);
        end
        n_checks++;
        if (got !== 3) begin
            n_fail++;
            $display("FAIL reset_mid_beats: got %0d expected 3", got);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_abort: got valid=%0b busy=%0b done=%0b expected 0/0/0", out_valid, busy, done);
        end
        rst_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done || out_valid) seen_done++;
        end
        n_checks++;
        if (seen_done !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: got %0d active cycles expected 0", seen_done);
        end
        begin
            int ex[8], ey[8], exb[8];
            ex = '{0, 1, 2, 3, 0, 1, 2, 3};
            ey = '{0, 0, 0, 0, 1, 1, 1, 1};
            exb = '{0, 0, 0, 0, 0, 0, 0, 0};
            start_frame(4, 2, 4, 2, 256, 256);
            capture(40);
            check_frame("reset_replay", 8, ex, ey, exb, 8'h88, 8'h80);
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_upscale();
        test_clamp();
        test_backpressure();
        test_zero_dim();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bicubic_phase_gen.md
# bicubic_phase_gen

Source-coordinate and blend-phase generator for the bicubic scaler. Walks the destination raster one pixel per accepted beat and emits the clamped integer source coordinate plus the 8-bit fractional blend for each axis. The outputs feed the bicubic weight units as `yBlend`, `coeffOne` and `coeffHalf`. It sits upstream of the weight pipeline and drives the tap-fetch address logic.

## Interface
- `FRAC_W`, 8, fraction bits. `coeff_one` = 1<<FRAC_W.
- `COORD_W`, 12, integer coordinate and dimension width.
- `STEP_W`, 20, step width, unsigned COORD_W.FRAC_W fixed point.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-high reset. Asserted = 1. The name is kept for codebase consistency.
- `start` in 1: frame start pulse. Sampled only in IDLE.
- `src_w`, `src_h` in COORD_W: source dimensions, used for clamping.
- `dst_w`, `dst_h` in COORD_W: destination dimensions.
- `step_x`, `step_y` in STEP_W: source advance per destination pixel or line (256 = 1.0).
- `out_ready` in 1: downstream accept.
- `out_valid` out 1: beat valid.
- `out_x_int`, `out_y_int` out COORD_W: clamped integer source coordinates.
- `x_blend`, `y_blend` out 9: {1'b0, fraction}, range 0..255.
- `coeff_one` out 9: constant 9'd256. `coeff_half` out 9: constant 9'd128.
- `out_eol` out 1, `out_eof` out 1: last pixel of the line / of the frame, qualified by `out_valid`.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse at frame end.

## Operation
- **FSM states:** IDLE, RUN, DONE.
  - IDLE → RUN on `start`. All config inputs are latched on the same edge.
  - IDLE → DONE on `start` if `dst_w`==0 or `dst_h`==0. No beats are emitted.
  - RUN → DONE on the handshake of the beat with `out_eof`=1.
  - DONE → IDLE unconditionally. `done`=1 only in DONE.
- `start` is ignored in RUN and DONE. Config inputs are ignored after latching.
- **Accumulators:** `acc_x` and `acc_y`, each COORD_W+FRAC_W bits, both reset to 0 at frame start.
  - Per handshake, not at end of line: `acc_x` += `step_x`.
  - Per handshake at end of line: `acc_x` ← 0, `acc_y` += `step_y`.
  - Addition saturates to all-ones; it never wraps.
- **Counters:** `dx` and `dy` count destination pixels. `out_eol` = (`dx`==`dst_w`−1). `out_eof` = `out_eol` && (`dy`==`dst_h`−1).
- **Integer part** is `acc[COORD_W+FRAC_W-1:FRAC_W]`. If it is ≥ src dimension, the output is src dimension−1 and the blend is forced to 0. Otherwise the output is the integer part and the blend is the fraction. Each axis is clamped independently.
- **Handshake:** registered valid/ready.
  - While `out_valid` && !`out_ready`, every output holds stable.
  - A beat transfers when both are high. The next beat is presented in the following cycle with no bubble.
- **Reset:** `rst_n`=1 forces IDLE on the next edge, regardless of state. Mid-frame it aborts without a `done` pulse.
- **Reset values:** `out_valid`, `busy`, `done`, `out_eol`, `out_eof` = 0. Coordinates and blends = 0. `coeff_one`/`coeff_half` are constants at all times.

## Timing
- `start` accepted at edge T → `out_valid`=1 after edge T+1, carrying (0,0) with blends 0.
- Throughput: 1 beat/cycle with `out_ready` held high. A frame takes `dst_w`·`dst_h` beats.
- Last handshake at edge L → `done`=1 during cycle L+1, state IDLE at L+2. A new `start` is accepted at L+2.
- Zero-dimension `start` at T → `done` during cycle T+1, `out_valid` never asserted.
- `out_ready` may toggle any cycle. No combinational path from `out_ready` to `out_valid`.

## Structure
- **Shared package `bicubic_pkg`:** FRAC_W, COEFF_ONE (256), COEFF_HALF (128), and the state encoding (IDLE/RUN/DONE). The bicubic weight units import the same constants.
- **Sub-module `bicubic_axis_acc`:** one instance per axis. It holds the accumulator, the saturating add, the clear, and the clamp-to-dimension logic. Outputs are int and blend.
- **Top level:** FSM, `dx`/`dy` counters, and the output register and handshake.

## Test plan
- **Identity:** src 4×2, dst 4×2, step 256/256, ready high → x_int 0,1,2,3 per line; y_int 0 then 1; all blends 0. `out_eol` on beats 3 and 7, `out_eof` on beat 7. `done` one cycle after beat 7.
- **2× upscale:** src 2×1, dst 4×1, step_x 128 → x_int 0,0,1,1 with x_blend 0,128,0,128. `coeff_one`=256 and `coeff_half`=128 throughout.
- **Clamp:** src 4×1, dst 4×1, step_x 384 → x_int 0,1,3,3 with x_blend 0,128,0,0.
- **Backpressure:** 2× upscale frame with `out_ready` low for 3 cycles after beat 1 → beat 1 values held unchanged for those cycles. Full sequence identical to the unstalled run; no beat lost or duplicated.
- **Zero dimension:** `dst_w`=0 with `start` → `out_valid` never high; `done` pulses one cycle after `start`.
- **Reset mid-frame:** `rst_n`=1 after 3 beats of a 4×2 frame → `out_valid`/`busy` low the next cycle, no `done`. A subsequent `start` replays the frame from (0,0).
